// File: rtl/dcache_refill_unit_if.sv
// Signal bundle between the L1 data cache, the refill unit and the memory bus.
// The master modport is the refill unit's side; the slave modport is the cache/memory side.
interface dcache_refill_unit_if #(
  parameter int unsigned LINE_SIZE  = 512,
  parameter int unsigned BEAT_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 64
) ();
  logic                  l1req_vld_i;
  logic                  l1req_ack_o;
  logic                  l1req_rd_i;
  logic [ADDR_WIDTH-1:0] l1req_addr_i;
  logic                  resp_vld_o;
  logic [LINE_SIZE-1:0]  resp_data_o;
  logic                  mem_req_vld_o;
  logic                  mem_req_rdy_i;
  logic [ADDR_WIDTH-1:0] mem_req_addr_o;
  logic                  mem_rsp_vld_i;
  logic [BEAT_WIDTH-1:0] mem_rsp_data_i;
  logic                  flush_i;

  modport master (
    input  l1req_vld_i, l1req_rd_i, l1req_addr_i, mem_req_rdy_i, mem_rsp_vld_i,
           mem_rsp_data_i, flush_i,
    output l1req_ack_o, resp_vld_o, resp_data_o, mem_req_vld_o, mem_req_addr_o
  );

  modport slave (
    output l1req_vld_i, l1req_rd_i, l1req_addr_i, mem_req_rdy_i, mem_rsp_vld_i,
           mem_rsp_data_i, flush_i,
    input  l1req_ack_o, resp_vld_o, resp_data_o, mem_req_vld_o, mem_req_addr_o
  );
endinterface

// File: rtl/dcache_refill_unit.sv
// L1 data-cache miss/refill engine: one outstanding line miss, fetched from memory as
// BEATS sequential beats and returned to the cache as a single-cycle full-line response.
module dcache_refill_unit #(
  parameter int unsigned LINE_SIZE    = 512,
  parameter int unsigned BEAT_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned OFFSET_WIDTH = 6
) (
  input logic                  clk,
  input logic                  rst,
  dcache_refill_unit_if.master bus
);
  localparam int unsigned BEATS = LINE_SIZE / BEAT_WIDTH;
  localparam int unsigned CNT_W = $clog2(BEATS);

  typedef enum logic [1:0] {StIdle, StReq, StFill, StResp} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  drop_q, drop_d;
  logic [LINE_SIZE-1:0]  line_q, line_d;
  logic                  ack, mem_req_vld, resp_vld;

  // Loads and stores refill identically; the offset is discarded by line alignment.
  logic unused_sigs;
  assign unused_sigs = ^{bus.l1req_rd_i, bus.l1req_addr_i[OFFSET_WIDTH-1:0]};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beat_cnt_d  = beat_cnt_q;
    drop_d      = drop_q;
    line_d      = line_q;
    ack         = 1'b0;
    mem_req_vld = 1'b0;
    resp_vld    = 1'b0;
    unique case (state_q)
      StIdle: begin
        ack = bus.l1req_vld_i & ~bus.flush_i;
        if (ack) begin
          addr_d     = {bus.l1req_addr_i[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
          drop_d     = 1'b0;
          beat_cnt_d = '0;
          state_d    = StReq;
        end
      end
      StReq: begin
        mem_req_vld = 1'b1;
        if (bus.mem_req_rdy_i) begin
          // Memory has committed to the read, so a flush can only suppress the response.
          state_d = StFill;
          if (bus.flush_i) drop_d = 1'b1;
        end else if (bus.flush_i) begin
          state_d = StIdle;
        end
      end
      StFill: begin
        if (bus.flush_i) drop_d = 1'b1;
        if (bus.mem_rsp_vld_i) begin
          line_d[int'(beat_cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] = bus.mem_rsp_data_i;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == CNT_W'(BEATS - 1)) state_d = StResp;
        end
      end
      StResp: begin
        resp_vld = ~drop_q & ~bus.flush_i;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      beat_cnt_q <= '0;
      drop_q     <= 1'b0;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_cnt_q <= beat_cnt_d;
      drop_q     <= drop_d;
      line_q     <= line_d;
    end
  end

  assign bus.l1req_ack_o    = ack;
  assign bus.mem_req_vld_o  = mem_req_vld;
  assign bus.mem_req_addr_o = addr_q;
  assign bus.resp_vld_o     = resp_vld;
  assign bus.resp_data_o    = line_q;
endmodule
